sha256_msg_padder: RTL and testbench

//  Front end of the SHA-256 accelerator. It reads an L-byte message from message SRAM and applies

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_msg_padder_if.sv | 20 ++
 rtl/sha256_pad_byte_sel.sv | 38 +++
 rtl/sha256_msg_padder.sv | 138 +++++++++++++
 tb/tb_sha256_msg_padder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and the padder state encoding for the SHA-256 front end.
package sha256_pkg;

    localparam int SHA_BLOCK_BYTES     = 64;
    localparam int SHA_WORDS_PER_BLOCK = 16;
    localparam int SHA_LEN_FIELD_BYTES = 8;
    localparam logic [7:0] SHA_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        DONE
    } pad_state_e;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Schedule-word stream from the padder to the compression core.
interface sha256_msg_padder_if;

    logic [31:0] pad__w__data;
    logic        pad__w__valid;
    logic        w__pad__ready;
    logic [3:0]  pad__w__index;
    logic        pad__w__block_last;

    modport master (
        output pad__w__data, pad__w__valid, pad__w__index, pad__w__block_last,
        input  w__pad__ready
    );

    modport slave (
        input  pad__w__data, pad__w__valid, pad__w__index, pad__w__block_last,
        output w__pad__ready
    );

endinterface

// File: rtl/sha256_pad_byte_sel.sv
// Chooses the padded-stream byte at position byte_idx: message byte, 0x80 marker,
// zero fill, or one byte of the big-endian 64-bit bit length.
module sha256_pad_byte_sel
    import sha256_pkg::*;
#(
    parameter int LW = 8,
    parameter int TW = 8
) (
    input  logic [TW-1:0] byte_idx,
    input  logic [LW-1:0] msg_len,
    input  logic [TW-1:0] total_len,
    input  logic [7:0]    mem_byte,
    output logic [7:0]    pad_byte
);

    logic [63:0]   bit_len;
    logic [TW-1:0] len_ext;
    logic [TW-1:0] len_start;
    logic [2:0]    k;

    always_comb begin
        bit_len   = 64'(msg_len) << 3;
        len_ext   = TW'(msg_len);
        len_start = total_len - TW'(SHA_LEN_FIELD_BYTES);
        k         = 3'(byte_idx - len_start);
        if (byte_idx < len_ext) begin
            pad_byte = mem_byte;
        end else if (byte_idx == len_ext) begin
            pad_byte = SHA_PAD_BYTE;
        end else if (byte_idx < len_start) begin
            pad_byte = 8'h00;
        end else begin
            // k = 0 selects the most significant byte of the length field
            pad_byte = 8'(bit_len >> {3'd7 - k, 3'b000});
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads message bytes from SRAM and streams padded
// 32-bit big-endian schedule words, block by block, over a valid/ready port.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int MAX_MESSAGE_LENGTH = 119,
    parameter int SYMBOL_WIDTH       = 8,
    localparam int LW = $clog2(MAX_MESSAGE_LENGTH) + 1,
    localparam int AW = $clog2(MAX_MESSAGE_LENGTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    xxx__dut__go,
    input  logic [LW-1:0]           xxx__dut__msg_length,
    output logic                    dut__xxx__finish,
    output logic                    dut__xxx__busy,
    output logic [AW-1:0]           dut__msg__address,
    output logic                    dut__msg__enable,
    output logic                    dut__msg__write,
    input  logic [SYMBOL_WIDTH-1:0] msg__dut__data,
    sha256_msg_padder_if.master     w_if
);

    localparam int MAX_BLOCKS = (MAX_MESSAGE_LENGTH + SHA_LEN_FIELD_BYTES) / SHA_BLOCK_BYTES + 1;
    localparam int MAX_T      = MAX_BLOCKS * SHA_BLOCK_BYTES;
    localparam int TW         = $clog2(MAX_T) + 1;

    generate
        if (SYMBOL_WIDTH != 8) begin : g_bad_symbol_width
            $error("sha256_msg_padder supports SYMBOL_WIDTH = 8 only");
        end
    endgenerate

    pad_state_e    state_q, state_d;
    logic [LW-1:0] l_q;
    logic [TW-1:0] t_q;
    logic [2:0]    phase_q;
    logic [3:0]    index_q;
    logic [31:0]   word_q;
    logic [TW-1:0] byte_idx_p0;
    logic [TW-1:0] byte_idx_p1;
    logic          vld_p1;

    logic [LW-1:0] l_clip;
    logic [31:0]   l_plus8;
    logic [TW-1:0] t_go;
    logic          issue;
    logic [7:0]    pad_byte;

    always_comb begin
        l_clip  = (xxx__dut__msg_length > LW'(MAX_MESSAGE_LENGTH)) ? LW'(MAX_MESSAGE_LENGTH)
                                                                   : xxx__dut__msg_length;
        l_plus8 = 32'(l_clip) + 32'(SHA_LEN_FIELD_BYTES);
        t_go    = TW'(((l_plus8 >> 6) << 6) + 32'(SHA_BLOCK_BYTES));
        issue   = (state_q == FETCH) && !phase_q[2];
    end

    sha256_pad_byte_sel #(.LW(LW), .TW(TW)) u_byte_sel (
        .byte_idx  (byte_idx_p1),
        .msg_len   (l_q),
        .total_len (t_q),
        .mem_byte  (msg__dut__data),
        .pad_byte  (pad_byte)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            l_q         <= '0;
            t_q         <= '0;
            phase_q     <= '0;
            index_q     <= '0;
            word_q      <= '0;
            byte_idx_p0 <= '0;
            byte_idx_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (xxx__dut__go) begin
                        l_q         <= l_clip;
                        t_q         <= t_go;
                        phase_q     <= '0;
                        index_q     <= '0;
                        byte_idx_p0 <= '0;
                        vld_p1      <= 1'b0;
                    end
                end
                FETCH: begin
                    // p0: issue byte (read when it is a message byte); p1: its value lands
                    if (issue) byte_idx_p0 <= byte_idx_p0 + TW'(1);
                    phase_q     <= phase_q + 3'd1;
                    byte_idx_p1 <= byte_idx_p0;
                    vld_p1      <= issue;
                    if (vld_p1) word_q <= {word_q[23:0], pad_byte};
                end
                EMIT: begin
                    if (w_if.w__pad__ready) begin
                        phase_q <= '0;
                        index_q <= index_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d                 = state_q;
        dut__xxx__finish        = 1'b0;
        dut__xxx__busy          = (state_q != IDLE);
        dut__msg__enable        = issue && (byte_idx_p0 < TW'(l_q));
        dut__msg__address       = '0;
        dut__msg__write         = 1'b0;
        w_if.pad__w__valid      = 1'b0;
        w_if.pad__w__block_last = 1'b0;
        w_if.pad__w__data       = word_q;
        w_if.pad__w__index      = index_q;
        if (dut__msg__enable) dut__msg__address = AW'(byte_idx_p0);
        unique case (state_q)
            IDLE:  if (xxx__dut__go) state_d = FETCH;
            FETCH: if (phase_q == 3'd4) state_d = EMIT;
            EMIT: begin
                w_if.pad__w__valid = 1'b1;
                // issue counter reaches T only once the final word of the final block is built
                w_if.pad__w__block_last = (byte_idx_p0 == t_q);
                if (w_if.w__pad__ready) state_d = (byte_idx_p0 == t_q) ? DONE : FETCH;
            end
            DONE: begin
                dut__xxx__finish = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: directed messages, backpressure and mid-run reset.
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    localparam int MAXL = 119;
    localparam int LW   = 8;
    localparam int AW   = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic [LW-1:0] msg_len = '0;
    logic          finish, busy, enable, write;
    logic [AW-1:0] address;
    logic [7:0]    msg_data = '0;

    sha256_msg_padder_if w_if ();

    sha256_msg_padder #(.MAX_MESSAGE_LENGTH(MAXL), .SYMBOL_WIDTH(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .xxx__dut__go         (go),
        .xxx__dut__msg_length (msg_len),
        .dut__xxx__finish     (finish),
        .dut__xxx__busy       (busy),
        .dut__msg__address    (address),
        .dut__msg__enable     (enable),
        .dut__msg__write      (write),
        .msg__dut__data       (msg_data),
        .w_if                 (w_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] rd_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            fin_cnt = 0;
    logic [7:0]    mem [0:127];

    // SRAM model: one-cycle read latency
    always @(posedge clk) if (enable) msg_data <= mem[address];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (w_if.pad__w__valid && w_if.w__pad__ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected word", {32'd0, w_if.pad__w__data}, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("word %0d data", e.idx), w_if.pad__w__data, e.data);
                    chk($sformatf("word %0d index", e.idx), w_if.pad__w__index, e.idx);
                    chk($sformatf("word %0d block_last", e.idx), w_if.pad__w__block_last, e.last);
                end
            end
            if (enable) begin
                if (rd_q.size() == 0) chk("unexpected read address", address, 64'hdead);
                else chk("read address", address, rd_q.pop_front());
            end
            if (finish) fin_cnt++;
        end
    end

    function automatic logic [31:0] mw(int b);
        return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
    endfunction

    task automatic push_w(logic [31:0] d, int k, bit last);
        exp_t e;
        e.data = d;
        e.idx  = 4'(k);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_reads(int n);
        for (int i = 0; i < n; i++) rd_q.push_back(AW'(i));
    endtask

    task automatic push_zeros(int from, int to);
        for (int k = from; k <= to; k++) push_w(32'h0, k, 1'b0);
    endtask

    task automatic check_quiet(string tag);
        chk({tag, " finish"}, finish, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " valid"}, w_if.pad__w__valid, 0);
        chk({tag, " enable"}, enable, 0);
        chk({tag, " address"}, address, 0);
        chk({tag, " write"}, write, 0);
        chk({tag, " data"}, w_if.pad__w__data, 0);
        chk({tag, " index"}, w_if.pad__w__index, 0);
        chk({tag, " block_last"}, w_if.pad__w__block_last, 0);
    endtask

    task automatic pulse_go(int len);
        @(posedge clk); #1;
        go      = 1'b1;
        msg_len = LW'(len);
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic run_msg(int len, bit stall, string tag);
        int f0, lat, cyc;
        logic [31:0] hold_d;
        f0 = fin_cnt;
        pulse_go(len);
        chk({tag, " busy after go"}, busy, 1);
        lat = 0;
        while (!w_if.pad__w__valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat > 6) begin
            n_fail++;
            $display("FAIL %s first-valid latency: got %0d cycles, limit 6", tag, lat);
        end
        cyc = 0;
        while (fin_cnt == f0 && cyc < 3000) begin
            if (stall && w_if.pad__w__valid && w_if.pad__w__index == 4'd5) begin
                hold_d = w_if.pad__w__data;
                w_if.w__pad__ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    @(posedge clk); #1;
                    chk({tag, " stall data"}, w_if.pad__w__data, hold_d);
                    chk({tag, " stall index"}, w_if.pad__w__index, 5);
                    chk({tag, " stall valid"}, w_if.pad__w__valid, 1);
                    chk({tag, " stall enable"}, enable, 0);
                end
                w_if.w__pad__ready = 1'b1;
                stall = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " finish seen"}, fin_cnt - f0, 1);
        chk({tag, " words left"}, exp_q.size(), 0);
        chk({tag, " reads left"}, rd_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " finish single pulse"}, fin_cnt - f0, 1);
        chk({tag, " busy after finish"}, busy, 0);
    endtask

    task automatic expect_abc();
        push_reads(3);
        push_w(32'h61626380, 0, 1'b0);
        push_zeros(1, 14);
        push_w(32'h00000018, 15, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int f0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        w_if.w__pad__ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b1;

        // L=0: single block, marker only
        push_w(32'h80000000, 0, 1'b0);
        push_zeros(1, 14);
        push_w(32'h00000000, 15, 1'b1);
        run_msg(0, 1'b0, "L0");

        // L=55: marker closes the only block
        push_reads(55);
        for (int k = 0; k < 13; k++) push_w(mw(4 * k), k, 1'b0);
        push_w(32'h34353680, 13, 1'b0);
        push_w(32'h00000000, 14, 1'b0);
        push_w(32'h000001B8, 15, 1'b1);
        run_msg(55, 1'b0, "L55");

        // L=56: length field spills into a second block
        push_reads(56);
        for (int k = 0; k < 14; k++) push_w(mw(4 * k), k, 1'b0);
        push_w(32'h80000000, 14, 1'b0);
        push_w(32'h00000000, 15, 1'b0);
        push_zeros(0, 14);
        push_w(32'h000001C0, 15, 1'b1);
        run_msg(56, 1'b0, "L56");

        // L=200 clips to 119
        push_reads(119);
        for (int k = 0; k < 16; k++) push_w(mw(4 * k), k, 1'b0);
        for (int k = 0; k < 13; k++) push_w(mw(64 + 4 * k), k, 1'b0);
        push_w(32'h74757680, 13, 1'b0);
        push_w(32'h00000000, 14, 1'b0);
        push_w(32'h000003B8, 15, 1'b1);
        run_msg(200, 1'b0, "L200");

        // L=100 aborted by reset during block 0
        push_reads(100);
        for (int k = 0; k < 16; k++) push_w(mw(4 * k), k, 1'b0);
        f0 = fin_cnt;
        pulse_go(100);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_quiet("abort");
        exp_q.delete();
        rd_q.delete();
        mem[0] = 8'h61;
        mem[1] = 8'h62;
        mem[2] = 8'h63;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort no finish", fin_cnt - f0, 0);
        chk("abort busy", busy, 0);

        // "abc" after the abort, then again under backpressure on W5
        expect_abc();
        run_msg(3, 1'b0, "abc");
        expect_abc();
        run_msg(3, 1'b1, "abc stall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
